// File: rtl/cdb_arbiter.sv
// Result collector for the common data bus: one small FIFO per functional unit,
// drained by a round-robin arbiter onto eight registered, gap-free CDB lanes.

package tomasula_types;
    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] value;
    } cdb_data;
endpackage

module cdb_arbiter #(
    parameter int NUM_FU     = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  tomasula_types::cdb_data fu_data [NUM_FU],
    output logic [NUM_FU-1:0]       fu_ready,
    output tomasula_types::cdb_data ctl_o [8],
    output logic [7:0]              enable_o
);
    localparam int LANES = 8;
    localparam int IW    = $clog2(NUM_FU);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    typedef tomasula_types::cdb_data data_t;

    data_t          mem    [NUM_FU][FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr [NUM_FU];
    logic [PW-1:0]  wr_ptr [NUM_FU];
    logic [CW-1:0]  count  [NUM_FU];
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  rr_next;

    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] grant;
    logic [LANES-1:0]  lane_en;
    data_t             lane_data [LANES];

    // Handshake: a result transfers at a rising edge where fu_valid[i] and
    // fu_ready[i] are both high. fu_ready looks only at the registered count,
    // so a pop in the same cycle never opens a slot early; a producer that
    // sees ready low must keep fu_valid and fu_data stable until it transfers.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = !rst && (count[i] != CW'(FIFO_DEPTH));
        end
        push = fu_valid & fu_ready;
    end

    // Walk every FU once starting at rr_ptr; the first eight non-empty FIFOs
    // claim lanes 0..7 in scan order, so enabled lanes are always contiguous.
    always_comb begin
        logic [IW-1:0] idx;
        logic [IW-1:0] last;
        logic [3:0]    ngrant;
        grant     = '0;
        lane_en   = '0;
        lane_data = '{default: '0};
        idx       = rr_ptr;
        last      = rr_ptr;
        ngrant    = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            if ((count[idx] != '0) && (ngrant < 4'd8)) begin
                grant[idx]               = 1'b1;
                lane_en[ngrant[2:0]]     = 1'b1;
                lane_data[ngrant[2:0]]   = mem[idx][rd_ptr[idx]];
                ngrant                   = ngrant + 4'd1;
                last                     = idx;
            end
            idx = (idx == IW'(NUM_FU - 1)) ? '0 : idx + IW'(1);
        end
        if (ngrant == '0) begin
            rr_next = rr_ptr;
        end else begin
            rr_next = (last == IW'(NUM_FU - 1)) ? '0 : last + IW'(1);
        end
    end

    // Storage has no reset; an entry is only ever read while its count says it is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (!flush && push[i]) begin
                mem[i][wr_ptr[i]] <= fu_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            rr_ptr   <= '0;
            enable_o <= '0;
            for (int k = 0; k < LANES; k++) begin
                ctl_o[k] <= '0;
            end
        end else if (flush) begin
            // Mispredict: drop everything buffered, keep the fairness pointer.
            for (int i = 0; i < NUM_FU; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            enable_o <= '0;
            for (int k = 0; k < LANES; k++) begin
                ctl_o[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (grant[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                count[i] <= count[i] + CW'(push[i]) - CW'(grant[i]);
            end
            rr_ptr   <= rr_next;
            enable_o <= lane_en;
            for (int k = 0; k < LANES; k++) begin
                ctl_o[k] <= lane_data[k];
            end
        end
    end

endmodule
